// File: rtl/conv_32_8_16_1_pkg.sv
// conv_32_8_16_1_pkg
//   Shared constants, types and helpers for the 32-sample, 8-tap, 16-bit,
//   single-MAC 1-D convolution core.
//   N    : input vector length
//   M    : filter taps
//   T    : sample / weight width
//   P    : number of MAC units
//   NOUT : outputs per vector (valid convolution, stride 1)
package conv_32_8_16_1_pkg;

   localparam int N    = 32;
   localparam int M    = 8;
   localparam int T    = 16;
   localparam int P    = 1;
   localparam int NOUT = N - M + 1;
   localparam int AW   = $clog2(N);
   localparam int JW   = $clog2(M);

   typedef logic signed [T-1:0]     sample_t;
   typedef logic signed [2*T+2:0]   acc_t;

   localparam sample_t SAT_MAX = 16'sh7FFF;
   localparam sample_t SAT_MIN = 16'sh8000;

   localparam sample_t F [M] = '{16'sd1, -16'sd2, 16'sd3, -16'sd4,
                                 16'sd4, -16'sd3, 16'sd2, -16'sd1};

   // Tap j lives in bits [j*T +: T]; this is the form the core takes as a
   // parameter so an instance can carry its own weight set.
   localparam logic [M*T-1:0] F_PACKED = {F[7], F[6], F[5], F[4],
                                          F[3], F[2], F[1], F[0]};

   // Clamp to the signed 16-bit range, then zero anything negative.
   function automatic sample_t sat_relu(input acc_t v);
      acc_t s;
      if (v > acc_t'(SAT_MAX))
         s = acc_t'(SAT_MAX);
      else if (v < acc_t'(SAT_MIN))
         s = acc_t'(SAT_MIN);
      else
         s = v;
      if (s < 0)
         return '0;
      return sample_t'(s[T-1:0]);
   endfunction

endpackage

// File: rtl/conv_32_8_16_1_core_mac.sv
// conv_mac
//   Registered signed multiply-accumulate with clear and a saturate+ReLU view
//   of the accumulator.
//   clk, reset : clock, async active-high reset
//   clr        : zero the accumulator (wins over accumulation)
//   en, last   : operand pair valid; last marks the final tap of an output
//   a, b       : signed sample and weight
//   y          : sat/ReLU of the accumulator
//   done       : accumulator holds the complete sum for the tap group
module conv_mac
   import conv_32_8_16_1_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    clr,
   input  logic    en,
   input  logic    last,
   input  sample_t a,
   input  sample_t b,
   output sample_t y,
   output logic    done
);

   localparam int PW = 2 * T;

   logic signed [PW-1:0] prod_q;
   logic                 prod_v;
   logic                 prod_last;
   acc_t                 acc_q;
   logic                 done_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prod_q    <= '0;
         prod_v    <= 1'b0;
         prod_last <= 1'b0;
         acc_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         prod_v    <= en;
         prod_last <= en && last;
         if (en)
            prod_q <= PW'(a) * PW'(b);
         // done trails the last product by one cycle, when acc_q includes it
         done_q    <= prod_v && prod_last;
         if (clr)
            acc_q <= '0;
         else if (prod_v)
            acc_q <= acc_q + acc_t'(prod_q);
      end
   end

   assign y    = sat_relu(acc_q);
   assign done = done_q;

endmodule

// File: rtl/conv_32_8_16_1_core.sv
// conv_32_8_16_1_core
//   Streaming valid-only 1-D convolution (32 samples x 8 taps -> 25 results)
//   with saturation and ReLU, one MAC.
//   clk, reset              : clock, async active-high reset
//   s_data_in_x/s_valid_x/
//   s_ready_x               : sample input stream
//   m_data_out_y/m_valid_y/
//   m_ready_y               : result output stream
//   WEIGHTS                 : packed taps, tap j at [j*T +: T]
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_LOAD    | accept 32 samples into x_mem
//   ST_COMPUTE | issue 8 MAC reads for output i, wait for the sum
//   ST_OUTPUT  | hold result i on the master port until accepted
module conv_32_8_16_1_core
   import conv_32_8_16_1_pkg::*;
#(
   parameter logic [M*T-1:0] WEIGHTS = F_PACKED
)(
   input  logic         clk,
   input  logic         reset,
   input  logic [T-1:0] s_data_in_x,
   input  logic         s_valid_x,
   output logic         s_ready_x,
   output logic [T-1:0] m_data_out_y,
   output logic         m_valid_y,
   input  logic         m_ready_y
);

   localparam logic [1:0] ST_LOAD    = 2'd0;
   localparam logic [1:0] ST_COMPUTE = 2'd1;
   localparam logic [1:0] ST_OUTPUT  = 2'd2;

   logic [1:0]    state;
   logic [AW-1:0] addr;
   logic [AW-1:0] i_idx;
   logic [JW-1:0] j_idx;
   logic          iss_q;
   logic          rd_v;
   logic          rd_last;
   logic          ready_q;
   logic          m_valid_q;
   logic [T-1:0]  y_q;

   logic [T-1:0]  x_mem [N];
   sample_t       x_rd;
   sample_t       w_rd;

   logic          ld_fire;
   logic          issue;
   logic [AW-1:0] rd_addr;
   sample_t       mac_y;
   logic          mac_done;

   assign ld_fire = (state == ST_LOAD) && ready_q && s_valid_x;
   assign issue   = (state == ST_COMPUTE) && iss_q;
   assign rd_addr = i_idx + AW'(j_idx);

   // Sample memory and the registered operand fetch; no reset needed since
   // every vector fully rewrites x_mem and rd_v qualifies the operands.
   always_ff @(posedge clk) begin
      if (ld_fire)
         x_mem[addr] <= s_data_in_x;
      x_rd <= sample_t'(x_mem[rd_addr]);
      w_rd <= sample_t'(WEIGHTS[j_idx*T +: T]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_LOAD;
         addr      <= '0;
         i_idx     <= '0;
         j_idx     <= '0;
         iss_q     <= 1'b0;
         rd_v      <= 1'b0;
         rd_last   <= 1'b0;
         ready_q   <= 1'b0;
         m_valid_q <= 1'b0;
         y_q       <= '0;
      end else begin
         rd_v    <= issue;
         rd_last <= issue && (j_idx == JW'(M - 1));
         case (state)
            ST_LOAD: begin
               ready_q <= 1'b1;
               if (ld_fire) begin
                  if (addr == AW'(N - 1)) begin
                     addr    <= '0;
                     j_idx   <= '0;
                     iss_q   <= 1'b1;
                     ready_q <= 1'b0;
                     state   <= ST_COMPUTE;
                  end else begin
                     addr <= addr + 1'b1;
                  end
               end
            end
            ST_COMPUTE: begin
               if (issue) begin
                  j_idx <= j_idx + 1'b1;
                  if (j_idx == JW'(M - 1))
                     iss_q <= 1'b0;
               end
               if (mac_done) begin
                  y_q       <= mac_y;
                  m_valid_q <= 1'b1;
                  state     <= ST_OUTPUT;
               end
            end
            ST_OUTPUT: begin
               if (m_ready_y) begin
                  m_valid_q <= 1'b0;
                  if (i_idx == AW'(NOUT - 1)) begin
                     i_idx   <= '0;
                     ready_q <= 1'b1;
                     state   <= ST_LOAD;
                  end else begin
                     i_idx <= i_idx + 1'b1;
                     j_idx <= '0;
                     iss_q <= 1'b1;
                     state <= ST_COMPUTE;
                  end
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

   // Accumulator is held at zero outside COMPUTE so each output starts clean.
   conv_mac u_mac (
      .clk   (clk),
      .reset (reset),
      .clr   (state != ST_COMPUTE),
      .en    (rd_v),
      .last  (rd_last),
      .a     (x_rd),
      .b     (w_rd),
      .y     (mac_y),
      .done  (mac_done)
   );

   assign s_ready_x    = ready_q;
   assign m_valid_y    = m_valid_q;
   assign m_data_out_y = y_q;

endmodule

// File: tb/tb_conv_32_8_16_1_core.sv
module tb_conv_32_8_16_1_core;

   logic        clk;
   logic        reset;
   logic [15:0] s_data_in_x;
   logic        s_valid_x;
   logic        s_ready_x;
   logic [15:0] m_data_out_y;
   logic        m_valid_y;
   logic        m_ready_y;

   logic        s_ready_p, m_valid_p;
   logic [15:0] m_data_p;
   logic        s_ready_n, m_valid_n;
   logic [15:0] m_data_n;

   int          total;
   int          bad;
   logic [15:0] xs [1280];
   int          exp_tab [25];
   int          fw [8] = '{1, -2, 3, -4, 4, -3, 2, -1};

   conv_32_8_16_1_core dut (
      .clk(clk), .reset(reset),
      .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
      .m_data_out_y(m_data_out_y), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y)
   );

   conv_32_8_16_1_core #(.WEIGHTS({8{16'h7FFF}})) dut_pos (
      .clk(clk), .reset(reset),
      .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_p),
      .m_data_out_y(m_data_p), .m_valid_y(m_valid_p), .m_ready_y(m_ready_y)
   );

   conv_32_8_16_1_core #(.WEIGHTS({8{16'h8000}})) dut_neg (
      .clk(clk), .reset(reset),
      .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_n),
      .m_data_out_y(m_data_n), .m_valid_y(m_valid_n), .m_ready_y(m_ready_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic int golden(input int v, input int i);
      longint acc;
      acc = 0;
      for (int j = 0; j < 8; j++)
         acc += longint'(fw[j]) * longint'($signed(xs[v*32 + i + j]));
      if (acc > 32767) acc = 32767;
      if (acc < 0) acc = 0;
      return int'(acc);
   endfunction

   // Drives nvec vectors from xs with pv/pr percent valid/ready and checks
   // every accepted result. stop_in / stop_out (>=0) abort early for the
   // reset tests; inputs are parked idle on exit.
   task automatic run_stream(input int nvec, input int pv, input int pr,
                             input bit use_tab, input bit sat_chk,
                             input int stop_in, input int stop_out,
                             input int budget);
      int sent, got, cyc, tot_in, tot_out, e;
      sent = 0; got = 0; cyc = 0;
      tot_in = nvec * 32;
      tot_out = nvec * 25;
      while (1) begin
         @(negedge clk);
         if (got >= tot_out || cyc >= budget) break;
         if (stop_in >= 0 && sent >= stop_in) break;
         if (stop_out >= 0 && got >= stop_out) break;
         s_valid_x = (sent < tot_in) && ($urandom_range(99) < pv);
         s_data_in_x = s_valid_x ? xs[sent] : 16'hxxxx;
         m_ready_y = ($urandom_range(99) < pr);
         if (s_valid_x && s_ready_x) sent++;
         if (m_valid_y && m_ready_y) begin
            e = use_tab ? exp_tab[got % 25] : golden(got / 25, got % 25);
            chk($sformatf("y%0d", got), 32'(m_data_out_y), e);
            if (sat_chk) begin
               chk($sformatf("pos_v%0d", got), 32'(m_valid_p), 1);
               chk($sformatf("pos_y%0d", got), 32'(m_data_p), 32767);
               chk($sformatf("neg_y%0d", got), 32'(m_data_n), 0);
            end
            got++;
         end
         cyc++;
      end
      s_valid_x = 1'b0;
      m_ready_y = 1'b0;
      if (stop_in < 0 && stop_out < 0) begin
         chk("n_in", sent, tot_in);
         chk("n_out", got, tot_out);
      end
   endtask

   initial begin
      int sent, cyc;
      total = 0;
      bad = 0;
      reset = 1'b1;
      s_valid_x = 1'b0;
      s_data_in_x = '0;
      m_ready_y = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(m_valid_y), 0);
      chk("rst_ready", 32'(s_ready_x), 0);
      chk("rst_data", 32'(m_data_out_y), 0);
      chk("rst_valid_p", 32'(m_valid_p), 0);
      chk("rst_ready_p", 32'(s_ready_p), 0);
      chk("rst_valid_n", 32'(m_valid_n), 0);
      chk("rst_ready_n", 32'(s_ready_n), 0);
      reset = 1'b0;
      @(negedge clk);

      // impulse at x[7]
      for (int k = 0; k < 32; k++) xs[k] = (k == 7) ? 16'd1 : 16'd0;
      for (int k = 0; k < 25; k++) exp_tab[k] = 0;
      exp_tab[1] = 2; exp_tab[3] = 4; exp_tab[5] = 3; exp_tab[7] = 1;
      run_stream(1, 100, 100, 1'b1, 1'b0, -1, -1, 2000);

      // ramp: every sum is negative, ReLU gives 0
      for (int k = 0; k < 32; k++) xs[k] = 16'(k);
      for (int k = 0; k < 25; k++) exp_tab[k] = 0;
      run_stream(1, 100, 100, 1'b1, 1'b0, -1, -1, 2000);

      // full-scale input: default taps sum to 0, override taps saturate
      for (int k = 0; k < 32; k++) xs[k] = 16'h7FFF;
      run_stream(1, 100, 100, 1'b1, 1'b1, -1, -1, 2000);

      // random data under random backpressure
      for (int k = 0; k < 1280; k++) xs[k] = 16'($urandom);
      run_stream(40, 70, 70, 1'b0, 1'b0, -1, -1, 40000);

      // reset after 20 samples
      for (int k = 0; k < 64; k++) xs[k] = 16'($urandom_range(0, 4000));
      run_stream(1, 100, 100, 1'b0, 1'b0, 20, -1, 2000);
      #2 reset = 1'b1;
      #1;
      chk("rst_in_valid", 32'(m_valid_y), 0);
      chk("rst_in_ready", 32'(s_ready_x), 0);
      @(negedge clk) reset = 1'b0;
      run_stream(1, 80, 80, 1'b0, 1'b0, -1, -1, 3000);

      // reset after 10 outputs of the second vector
      for (int k = 0; k < 64; k++) xs[k] = 16'($urandom);
      run_stream(2, 100, 100, 1'b0, 1'b0, -1, 35, 5000);
      #2 reset = 1'b1;
      #1;
      chk("rst_out_valid", 32'(m_valid_y), 0);
      chk("rst_out_data", 32'(m_data_out_y), 0);
      chk("rst_out_ready", 32'(s_ready_x), 0);
      @(negedge clk) reset = 1'b0;
      for (int k = 0; k < 32; k++) xs[k] = 16'($urandom);
      run_stream(1, 60, 60, 1'b0, 1'b0, -1, -1, 3000);

      // stall: x[0]=5 gives y[0]=5, held for 50 cycles without ready
      for (int k = 0; k < 32; k++) xs[k] = (k == 0) ? 16'd5 : 16'd0;
      sent = 0;
      cyc = 0;
      while (sent < 32 && cyc < 200) begin
         @(negedge clk);
         s_valid_x = 1'b1;
         s_data_in_x = xs[sent];
         m_ready_y = 1'b0;
         if (s_ready_x) sent++;
         cyc++;
      end
      @(negedge clk);
      s_valid_x = 1'b0;
      chk("stall_loaded", sent, 32);
      cyc = 0;
      while (!m_valid_y && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("stall_wait", 32'(m_valid_y), 1);
      for (int k = 0; k < 50; k++) begin
         chk($sformatf("stall_y%0d", k), 32'(m_data_out_y), 5);
         chk($sformatf("stall_v%0d", k), 32'(m_valid_y), 1);
         chk($sformatf("stall_r%0d", k), 32'(s_ready_x), 0);
         @(negedge clk);
      end
      m_ready_y = 1'b1;
      @(negedge clk);
      m_ready_y = 1'b0;
      chk("stall_acc", 32'(m_valid_y), 0);
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
